// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - forwarding encodings, scoreboard states and shadow slot record
package pipe_pkg;

    // Slot destination field is sized for the widest supported register file.
    localparam int SLOT_DST_W = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_DST_W-1:0] dst;
        logic                  rf_en;
        logic                  load;
        logic                  mem_en;
    } slot_t;

    function automatic logic slot_hit(input slot_t s, input logic [SLOT_DST_W-1:0] src);
        return s.valid && s.rf_en && (s.dst == src);
    endfunction

endpackage

// File: rtl/hazard_slot.sv
// rtl/hazard_slot.sv - one shadow pipeline slot with hold and bubble clear
module hazard_slot
    import pipe_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_hold,
    input  logic  i_clear,
    input  slot_t i_d,
    output slot_t o_q
);

    slot_t r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (!i_hold) begin
            r_q <= i_clear ? '0 : i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - operand forwarding select, load-use stall, branch flush and memory wait control
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int RADDR_W = 4,
    parameter int MEM_LAT = 1
)(
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       id_valid,
    input  logic [NUM_SRC*RADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [RADDR_W-1:0]         id_dst_addr,
    input  logic                       id_rf_enable,
    input  logic                       id_load,
    input  logic                       id_mem_enable,
    input  logic                       ex_branch_taken,
    output logic [NUM_SRC*2-1:0]       fwd_sel,
    output logic                       pc_enable,
    output logic                       ifid_le,
    output logic                       nop_insert,
    output logic                       ifid_flush,
    output logic                       pipe_hold
);

    localparam logic               USE_WAIT  = (MEM_LAT > 1);
    localparam logic [3:0]         WAIT_LOAD = USE_WAIT ? 4'(MEM_LAT - 2) : 4'd0;
    localparam logic [RADDR_W-1:0] PC_REG    = '1;

    state_e     r_state;
    logic [3:0] r_cnt;
    slot_t      w_id_slot;
    slot_t      w_ex;
    slot_t      w_mem;
    slot_t      w_wb;
    logic       w_hold;
    logic       w_branch;
    logic       w_lu_hazard;
    logic       w_wait_start;
    logic       w_unused_bits;

    assign w_id_slot = '{valid:  id_valid,
                         dst:    SLOT_DST_W'(id_dst_addr),
                         rf_en:  id_rf_enable,
                         load:   id_load,
                         mem_en: id_mem_enable};

    hazard_slot u_ex_slot (
        .i_clk(CLK), .i_rst_n(CLR), .i_hold(pipe_hold),
        .i_clear(nop_insert || ifid_flush), .i_d(w_id_slot), .o_q(w_ex)
    );

    hazard_slot u_mem_slot (
        .i_clk(CLK), .i_rst_n(CLR), .i_hold(pipe_hold),
        .i_clear(1'b0), .i_d(w_ex), .o_q(w_mem)
    );

    hazard_slot u_wb_slot (
        .i_clk(CLK), .i_rst_n(CLR), .i_hold(pipe_hold),
        .i_clear(1'b0), .i_d(w_mem), .o_q(w_wb)
    );

    assign w_unused_bits = ^{w_mem.load, w_mem.mem_en, w_wb.load, w_wb.mem_en};

    assign w_hold   = (r_state == ST_MEM_WAIT);
    assign w_branch = ex_branch_taken && CLR && !w_hold;

    // The wait starts on the edge that moves a memory op from EX into MEM,
    // so the op occupies MEM for exactly MEM_LAT cycles.
    assign w_wait_start = USE_WAIT && !w_hold && w_ex.valid && w_ex.mem_en;

    always_comb begin
        fwd_sel     = '0;
        w_lu_hazard = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_src_used[k] && (id_src_addr[k*RADDR_W +: RADDR_W] != PC_REG)) begin
                if (slot_hit(w_ex, SLOT_DST_W'(id_src_addr[k*RADDR_W +: RADDR_W])))
                    fwd_sel[2*k +: 2] = FWD_EX;
                else if (slot_hit(w_mem, SLOT_DST_W'(id_src_addr[k*RADDR_W +: RADDR_W])))
                    fwd_sel[2*k +: 2] = FWD_MEM;
                else if (slot_hit(w_wb, SLOT_DST_W'(id_src_addr[k*RADDR_W +: RADDR_W])))
                    fwd_sel[2*k +: 2] = FWD_WB;
            end
            if (id_src_used[k] && w_ex.valid && w_ex.load &&
                (w_ex.dst == SLOT_DST_W'(id_src_addr[k*RADDR_W +: RADDR_W])))
                w_lu_hazard = 1'b1;
        end
    end

    always_comb begin
        pc_enable  = 1'b1;
        ifid_le    = 1'b1;
        nop_insert = 1'b0;
        ifid_flush = 1'b0;
        pipe_hold  = 1'b0;
        if (w_hold) begin
            pipe_hold = 1'b1;
            pc_enable = 1'b0;
            ifid_le   = 1'b0;
        end else if (w_branch) begin
            ifid_flush = 1'b1;
            nop_insert = 1'b1;
        end else if (w_lu_hazard) begin
            pc_enable  = 1'b0;
            ifid_le    = 1'b0;
            nop_insert = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_RUN, ST_LU_STALL: begin
                    if (w_wait_start) begin
                        r_state <= ST_MEM_WAIT;
                        r_cnt   <= WAIT_LOAD;
                    end else if ((r_state == ST_RUN) && !w_branch && w_lu_hazard) begin
                        r_state <= ST_LU_STALL;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (r_cnt == 4'd0)
                        r_state <= ST_RUN;
                    else
                        r_cnt <= r_cnt - 4'd1;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard against an instruction-level pipeline model
module tb_hazard_scoreboard;

    localparam int NS  = 3;
    localparam int AW  = 4;
    localparam int LAT = 3;

    logic           CLK = 1'b0;
    logic           CLR;
    logic           id_valid;
    logic [NS*AW-1:0] id_src_addr;
    logic [NS-1:0]  id_src_used;
    logic [AW-1:0]  id_dst_addr;
    logic           id_rf_enable;
    logic           id_load;
    logic           id_mem_enable;
    logic           ex_branch_taken;
    logic [NS*2-1:0] fwd_sel;
    logic           pc_enable;
    logic           ifid_le;
    logic           nop_insert;
    logic           ifid_flush;
    logic           pipe_hold;

    always #5 CLK = ~CLK;

    hazard_scoreboard #(.NUM_SRC(NS), .RADDR_W(AW), .MEM_LAT(LAT)) dut (
        .CLK(CLK), .CLR(CLR), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_rf_enable(id_rf_enable),
        .id_load(id_load), .id_mem_enable(id_mem_enable), .ex_branch_taken(ex_branch_taken),
        .fwd_sel(fwd_sel), .pc_enable(pc_enable), .ifid_le(ifid_le), .nop_insert(nop_insert),
        .ifid_flush(ifid_flush), .pipe_hold(pipe_hold)
    );

    typedef struct packed {
        logic       v;
        logic [3:0] dst;
        logic       rf;
        logic       ld;
        logic       me;
    } ins_t;

    // In-flight instructions: index 0 = EX, 1 = MEM, 2 = WB.
    ins_t pipe_m [3];
    int   wait_left = 0;
    logic m_le   = 1'b1;
    logic m_hold = 1'b0;

    logic [10:0] exp_q [$];
    string       tag_q [$];
    int n_pass  = 0;
    int n_total = 0;

    localparam ins_t IDLE = '0;

    function automatic ins_t mk(input logic v, input logic [3:0] d, input logic rf,
                                input logic ld, input logic me);
        return {v, d, rf, ld, me};
    endfunction

    function automatic logic [3:0] rnd_reg();
        if ($urandom_range(0, 9) == 0) return 4'hF;
        return 4'($urandom_range(0, 3));
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i;
        i.v   = ($urandom_range(0, 9) != 0);
        i.dst = rnd_reg();
        i.rf  = ($urandom_range(0, 3) != 0);
        i.ld  = ($urandom_range(0, 3) == 0);
        i.me  = i.ld | ($urandom_range(0, 7) == 0);
        return i;
    endfunction

    task automatic step(input logic rst, input ins_t id, input logic [11:0] src,
                        input logic [2:0] used, input logic br, input string tag);
        logic [5:0] fwd;
        logic [3:0] s;
        logic hold, brk, lu, pc, le, nop, fl;
        CLR             = !rst;
        id_valid        = id.v;
        id_dst_addr     = id.dst;
        id_rf_enable    = id.rf;
        id_load         = id.ld;
        id_mem_enable   = id.me;
        id_src_addr     = src;
        id_src_used     = used;
        ex_branch_taken = br;
        if (rst) begin
            for (int j = 0; j < 3; j++) pipe_m[j] = '0;
            wait_left = 0;
        end
        fwd = '0;
        lu  = 1'b0;
        for (int k = 0; k < NS; k++) begin
            s = src[k*4 +: 4];
            if (used[k]) begin
                if (s != 4'hF)
                    for (int j = 2; j >= 0; j--)
                        if (pipe_m[j].v && pipe_m[j].rf && pipe_m[j].dst == s)
                            fwd[k*2 +: 2] = 2'(j + 1);
                if (pipe_m[0].v && pipe_m[0].ld && pipe_m[0].dst == s) lu = 1'b1;
            end
        end
        hold = (wait_left > 0);
        brk  = br && !rst && !hold;
        pc = 1'b1; le = 1'b1; nop = 1'b0; fl = 1'b0;
        if (hold) begin
            pc = 1'b0; le = 1'b0;
        end else if (brk) begin
            nop = 1'b1; fl = 1'b1;
        end else if (lu) begin
            pc = 1'b0; le = 1'b0; nop = 1'b1;
        end
        exp_q.push_back({fwd, pc, le, nop, fl, hold});
        tag_q.push_back(tag);
        m_le   = le;
        m_hold = hold;
        @(posedge CLK);
        if (rst) begin
            for (int j = 0; j < 3; j++) pipe_m[j] = '0;
            wait_left = 0;
        end else if (hold) begin
            wait_left--;
        end else begin
            pipe_m[2] = pipe_m[1];
            pipe_m[1] = pipe_m[0];
            pipe_m[0] = id;
            if (nop) pipe_m[0].v = 1'b0;
            if (pipe_m[1].v && pipe_m[1].me) wait_left = LAT - 1;
        end
        #1;
    endtask

    initial begin : monitor
        logic [10:0] act;
        logic [10:0] e;
        string t;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                act = {fwd_sel, pc_enable, ifid_le, nop_insert, ifid_flush, pipe_hold};
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                n_total++;
                if (act === e) n_pass++;
                else $display("FAIL %s: got fwd_sel=%b pc/le/nop/flush/hold=%b, expected fwd_sel=%b pc/le/nop/flush/hold=%b",
                              t, act[10:5], act[4:0], e[10:5], e[4:0]);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_total);
        $fatal(1);
    end

    initial begin : stimulus
        ins_t cur;
        logic [11:0] src;
        logic [2:0] used;
        logic br;
        for (int j = 0; j < 3; j++) pipe_m[j] = '0;
        CLR = 1'b0; id_valid = 1'b0; id_src_addr = '0; id_src_used = '0; id_dst_addr = '0;
        id_rf_enable = 1'b0; id_load = 1'b0; id_mem_enable = 1'b0; ex_branch_taken = 1'b0;
        @(posedge CLK);
        #1;
        step(1'b1, IDLE, '0, 3'b000, 1'b0, "reset");
        step(1'b1, mk(1, 4'd1, 1, 0, 0), 12'h111, 3'b111, 1'b1, "reset_busy_inputs");
        step(1'b0, IDLE, '0, 3'b000, 1'b0, "idle");

        step(1'b0, mk(1, 4'd1, 1, 0, 0), '0, 3'b000, 1'b0, "add_r1");
        step(1'b0, mk(1, 4'd5, 1, 0, 0), {4'd0, 4'd0, 4'd1}, 3'b001, 1'b0, "fwd_ex_p0");

        step(1'b0, mk(1, 4'd2, 1, 1, 1), '0, 3'b000, 1'b0, "ldr_r2");
        repeat (4) step(1'b0, mk(1, 4'd6, 1, 0, 0), {4'd0, 4'd2, 4'd0}, 3'b010, 1'b0, "load_use_p1");
        repeat (2) step(1'b0, IDLE, '0, 3'b000, 1'b0, "drain");

        step(1'b0, mk(1, 4'd0, 0, 0, 1), '0, 3'b000, 1'b0, "store");
        repeat (4) step(1'b0, IDLE, '0, 3'b000, 1'b0, "store_wait");

        step(1'b0, mk(1, 4'd4, 1, 1, 0), '0, 3'b000, 1'b0, "ldr_r4");
        step(1'b0, mk(1, 4'd7, 1, 0, 0), {4'd0, 4'd0, 4'd4}, 3'b001, 1'b1, "branch_and_load_use");
        repeat (2) step(1'b0, IDLE, '0, 3'b000, 1'b0, "after_branch");

        step(1'b0, mk(1, 4'd3, 1, 0, 0), '0, 3'b000, 1'b0, "write_r3_a");
        step(1'b0, mk(1, 4'd15, 1, 0, 0), '0, 3'b000, 1'b0, "write_r15");
        step(1'b0, mk(1, 4'd3, 1, 0, 0), '0, 3'b000, 1'b0, "write_r3_b");
        step(1'b0, mk(1, 4'd8, 1, 0, 0), {4'd3, 4'd0, 4'd15}, 3'b101, 1'b0, "ex_priority_and_r15");
        repeat (3) step(1'b0, IDLE, '0, 3'b000, 1'b0, "drain2");

        step(1'b0, mk(1, 4'd0, 0, 0, 1), '0, 3'b000, 1'b0, "store2");
        step(1'b0, IDLE, '0, 3'b000, 1'b0, "store2_wait");
        step(1'b1, mk(1, 4'd9, 1, 0, 0), {4'd0, 4'd0, 4'd0}, 3'b001, 1'b1, "reset_in_mem_wait");
        repeat (3) step(1'b0, IDLE, '0, 3'b000, 1'b0, "after_reset");

        cur = IDLE; src = '0; used = '0; br = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (m_le) begin
                cur  = rnd_ins();
                src  = {rnd_reg(), rnd_reg(), rnd_reg()};
                used = 3'($urandom_range(0, 7));
            end
            if (!m_hold) br = ($urandom_range(0, 7) == 0);
            step(($urandom_range(0, 99) == 0), cur, src, used, br, "random");
        end

        @(negedge CLK);
        #1;
        if (exp_q.size() != 0)
            $display("FAIL completion: got %0d unchecked expectations, expected 0", exp_q.size());
        if (n_total < 12)
            $display("FAIL coverage: got %0d checks, expected at least 12", n_total);
        if (n_pass != n_total)
            $display("FAIL summary: got %0d passing checks, expected %0d", n_pass, n_total);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
